// File: rtl/sram_pkg.sv
// Shared SRAM controller geometry, scrubber FSM states and the byte-parity
// definition used by both the write path and the read-side checkers.
package sram_pkg;

    typedef struct packed {
        int AW;      // word address width
        int DW;      // data width
        int PW;      // parity width, one bit per (possibly partial) byte
        int WCNT;    // number of words in the array
        bit isPRT;   // parity protection present
        int EVITVL;  // idle cycles between scrub reads
    } sramcfg_t;

    localparam sramcfg_t samplecfg = '{AW: 10, DW: 32, PW: 4, WCNT: 1024,
                                       isPRT: 1'b1, EVITVL: 15};

    typedef enum logic [1:0] {IDLE, WAIT, REQ, RESP} scrub_st_e;

    localparam int MAXDW = 256;
    localparam int MAXPW = MAXDW / 8;

    // Even parity per byte; callers zero-extend data so a partial top byte
    // is covered by bit pw-1 and bits at or above pw come back as 0.
    function automatic logic [MAXPW-1:0] byte_parity(input logic [MAXDW-1:0] data,
                                                     input int pw);
        logic [MAXPW-1:0] p;
        p = '0;
        for (int i = 0; i < MAXPW; i++) begin
            if (i < pw) p[i] = ^data[8*i +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/gnrl_sramc_parchk.sv
// Combinational parity check of a returned SRAM word against its stored
// parity; shared by the scrubber and the functional read path.
module gnrl_sramc_parchk
    import sram_pkg::*;
#(
    parameter int DW = 32,
    parameter int PW = 4,
    parameter bit EN = 1'b1
) (
    input  logic [DW-1:0] data,
    input  logic [PW-1:0] par,
    output logic          mismatch
);

    logic [MAXPW-1:0] par_exp;

    always_comb begin
        par_exp  = byte_parity(MAXDW'(data), PW);
        mismatch = EN && (par_exp != MAXPW'(par));
    end

endmodule

// File: rtl/gnrl_sramc_scrub.sv
// Background parity scrubber: walks every word through the controller read
// port at a fixed interval and reports mismatching addresses and a count.
module gnrl_sramc_scrub
    import sram_pkg::*;
#(
    parameter sramcfg_t CFG = samplecfg,
    parameter int       ECW = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              en,
    input  logic              err_clr,
    output logic              scrub_req,
    output logic [CFG.AW-1:0] scrub_addr,
    input  logic              scrub_gnt,
    input  logic              scrub_rvld,
    input  logic [CFG.DW-1:0] scrub_rdata,
    input  logic [CFG.PW-1:0] scrub_rpar,
    output logic              err_pulse,
    output logic [CFG.AW-1:0] err_addr,
    output logic [ECW-1:0]    err_cnt,
    output logic              pass_done
);

    localparam int            AW   = CFG.AW;
    localparam int            CW   = $clog2(CFG.EVITVL) + 1;
    localparam logic [AW-1:0] LAST = AW'(CFG.WCNT - 1);
    localparam logic [CW-1:0] ITVL_END = CW'(CFG.EVITVL - 1);

    scrub_st_e     state, nstate;
    logic [CW-1:0] cnt;
    logic [AW-1:0] addr;
    logic          chk_vld;
    logic          mismatch;
    logic          err_ev;

    gnrl_sramc_parchk #(
        .DW (CFG.DW),
        .PW (CFG.PW),
        .EN (CFG.isPRT)
    ) u_parchk (
        .data     (scrub_rdata),
        .par      (scrub_rpar),
        .mismatch (mismatch)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= nstate;
    end

    // A grant wins over a same-cycle disable so the accepted read completes.
    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (en) nstate = WAIT;
            WAIT:    if (!en) nstate = IDLE;
                     else if (cnt == ITVL_END) nstate = REQ;
            REQ:     if (scrub_gnt) nstate = RESP;
                     else if (!en) nstate = IDLE;
            RESP:    if (scrub_rvld) nstate = en ? WAIT : IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        scrub_req  = (state == REQ);
        scrub_addr = addr;
        chk_vld    = (state == RESP) && scrub_rvld;
        err_ev     = chk_vld && mismatch;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt       <= '0;
            addr      <= '0;
            err_pulse <= 1'b0;
            err_addr  <= '0;
            err_cnt   <= '0;
            pass_done <= 1'b0;
        end else begin
            cnt       <= (state == WAIT) ? cnt + 1'b1 : '0;
            err_pulse <= err_ev;
            pass_done <= chk_vld && (addr == LAST);
            if (chk_vld) addr <= (addr == LAST) ? '0 : addr + 1'b1;
            if (err_ev) err_addr <= addr;
            // A clear coinciding with a new mismatch leaves exactly that one counted.
            if (err_clr)                     err_cnt <= ECW'(err_ev);
            else if (err_ev && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_gnrl_sramc_scrub.sv
// Bench for gnrl_sramc_scrub: transaction-level model checked every cycle plus
// directed scenarios with hand-computed literal expectations.
module tb_gnrl_sramc_scrub;
    import sram_pkg::*;

    localparam int AW = 10, DW = 32, PW = 4, WCNT = 1024;
    localparam int ECW = 16, ECS = 4;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    logic en = 1'b0, err_clr = 1'b0, scrub_gnt = 1'b1, scrub_rvld = 1'b0;
    logic [DW-1:0] scrub_rdata = '0;
    logic [PW-1:0] scrub_rpar = '0;

    logic scrub_req, err_pulse, pass_done;
    logic [AW-1:0] scrub_addr, err_addr;
    logic [ECW-1:0] err_cnt;
    logic s_req, s_pulse, s_done;
    logic [AW-1:0] s_addr, s_eaddr;
    logic [ECS-1:0] s_cnt;

    int n_cmp = 0, n_bad = 0;

    // responder controls
    logic resp_auto = 1'b1, inj_rvld = 1'b0, clr_req = 1'b0;
    logic g_seen = 1'b0;
    logic [AW-1:0] g_addr = '0;

    always #5 clk = ~clk;

    gnrl_sramc_scrub #(.CFG(samplecfg), .ECW(ECW)) dut (
        .clk(clk), .resetn(resetn), .en(en), .err_clr(err_clr),
        .scrub_req(scrub_req), .scrub_addr(scrub_addr), .scrub_gnt(scrub_gnt),
        .scrub_rvld(scrub_rvld), .scrub_rdata(scrub_rdata), .scrub_rpar(scrub_rpar),
        .err_pulse(err_pulse), .err_addr(err_addr), .err_cnt(err_cnt),
        .pass_done(pass_done)
    );

    gnrl_sramc_scrub #(.CFG(samplecfg), .ECW(ECS)) dut_sat (
        .clk(clk), .resetn(resetn), .en(en), .err_clr(err_clr),
        .scrub_req(s_req), .scrub_addr(s_addr), .scrub_gnt(scrub_gnt),
        .scrub_rvld(scrub_rvld), .scrub_rdata(scrub_rdata), .scrub_rpar(scrub_rpar),
        .err_pulse(s_pulse), .err_addr(s_eaddr), .err_cnt(s_cnt),
        .pass_done(s_done)
    );

    function automatic logic [PW-1:0] par_of(input logic [DW-1:0] d);
        logic [PW-1:0] p;
        for (int i = 0; i < PW; i++) p[i] = ^d[8*i +: 8];
        return p;
    endfunction

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        return 32'(a) * 32'h9E3779B1 + 32'h12345677;
    endfunction

    // Memory image: addr 5 holds 0xFF with wrong byte-0 parity; 100..119 and
    // 200 have a flipped top parity bit; read of 200 arrives with err_clr.
    always @(negedge clk) begin
        g_seen = resp_auto && resetn && scrub_req && scrub_gnt;
        g_addr = scrub_addr;
    end

    always @(posedge clk) begin
        logic [DW-1:0] d;
        logic [PW-1:0] p;
        #1;
        if (g_seen) begin
            d = word_of(g_addr);
            p = par_of(d);
            if (g_addr == 10'd5) begin
                d = 32'h000000FF;
                p = 4'b0001;
            end else if ((g_addr >= 10'd100 && g_addr <= 10'd119) || g_addr == 10'd200) begin
                p = p ^ 4'b1000;
            end
            scrub_rvld  = 1'b1;
            scrub_rdata = d;
            scrub_rpar  = p;
            err_clr     = (g_addr == 10'd200) || clr_req;
        end else if (inj_rvld) begin
            scrub_rvld  = 1'b1;
            scrub_rdata = 32'h000000FF;
            scrub_rpar  = 4'b0001;
            err_clr     = clr_req;
        end else begin
            scrub_rvld  = 1'b0;
            err_clr     = clr_req;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // negedges from the current point until scrub_req is seen high
    task automatic cycles_to_req(input int maxc, output int k);
        k = 0;
        @(negedge clk);
        while (!scrub_req && k < maxc) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic cycles_to_next_req(input int maxc, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!scrub_req && k < maxc);
    endtask

    task automatic wait_addr(input int target, input int maxc, output bit ok);
        int k;
        k = 0;
        ok = 1'b0;
        while (k < maxc && !ok) begin
            @(negedge clk);
            k++;
            if (scrub_req && int'(scrub_addr) == target) ok = 1'b1;
        end
    endtask

    task automatic wait_pulse(input int maxc, output bit ok);
        int k;
        k = 0;
        ok = 1'b0;
        while (k < maxc && !ok) begin
            @(negedge clk);
            k++;
            if (err_pulse) ok = 1'b1;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // model state
        int m_addr, m_cnt, m_cnts, n_done;
        logic m_out, e_pulse, e_done, mis;
        logic [AW-1:0] m_eaddr;
        m_addr = 0; m_cnt = 0; m_cnts = 0; n_done = 0;
        m_out = 0; e_pulse = 0; e_done = 0; m_eaddr = '0;

        fork
            begin : stim
                int k;
                bit ok;
                #1 resetn = 1'b0;
                repeat (3) @(posedge clk);
                #1 resetn = 1'b1;
                @(posedge clk);
                #1 en = 1'b1;

                // first request EVITVL cycles after en sampled, then 17 cycles apart
                @(posedge clk);
                cycles_to_req(100, k);
                chk("first_req_latency", k, 15);
                chk("first_req_addr", scrub_addr, 0);
                cycles_to_next_req(100, k);
                chk("second_req_spacing", k, 17);
                chk("second_req_addr", scrub_addr, 1);

                // parity error on word 5
                wait_pulse(200, ok);
                chk("err_pulse_seen", ok, 1);
                chk("err_addr_w5", err_addr, 10'h005);
                chk("err_cnt_w5", err_cnt, 1);

                // standalone clear
                @(negedge clk);
                clr_req = 1'b1;
                @(negedge clk);
                clr_req = 1'b0;
                @(negedge clk);
                chk("err_cnt_cleared", err_cnt, 0);
                chk("err_addr_kept", err_addr, 10'h005);

                // request held without grant, then dropped on disable
                @(posedge clk);
                #1 scrub_gnt = 1'b0;
                cycles_to_next_req(100, k);
                chk("held_req_addr", scrub_addr, 6);
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    chk("req_held", scrub_req, 1);
                    chk("addr_held", scrub_addr, 6);
                end
                @(posedge clk);
                #1 en = 1'b0;
                @(negedge clk);
                @(negedge clk);
                chk("req_dropped", scrub_req, 0);
                repeat (3) @(posedge clk);
                #1 begin en = 1'b1; scrub_gnt = 1'b1; end
                @(posedge clk);
                cycles_to_req(100, k);
                chk("resume_latency", k, 15);
                chk("resume_addr", scrub_addr, 6);

                // saturation and clear-with-mismatch
                wait_addr(130, 4000, ok);
                chk("reach_130", ok, 1);
                chk("err_cnt_after_burst", err_cnt, 20);
                chk("sat_cnt_after_burst", s_cnt, 4'hF);
                wait_addr(202, 2000, ok);
                chk("reach_202", ok, 1);
                chk("err_cnt_clr_same_cycle", err_cnt, 1);
                chk("sat_cnt_clr_same_cycle", s_cnt, 1);
                chk("err_addr_200", err_addr, 10'h0C8);

                // wrap to address 0
                wait_addr(0, 20000, ok);
                chk("wrap_reached", ok, 1);
                chk("pass_done_count", n_done, 1);

                // reset while a read is outstanding
                @(posedge clk);
                #3 resp_auto = 1'b0;
                cycles_to_next_req(100, k);
                chk("resp_req_addr", scrub_addr, 1);
                @(posedge clk);
                #2 begin resetn = 1'b0; en = 1'b0; end
                repeat (2) @(posedge clk);
                #1 resetn = 1'b1;
                @(negedge clk);
                inj_rvld = 1'b1;
                @(negedge clk);
                inj_rvld = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("post_reset_idle", scrub_req, 0);
                    chk("post_reset_no_err", err_pulse, 0);
                end
                chk("post_reset_cnt", err_cnt, 0);
                @(posedge clk);
                #1 begin en = 1'b1; resp_auto = 1'b1; end
                @(posedge clk);
                cycles_to_req(100, k);
                chk("post_reset_latency", k, 15);
                chk("post_reset_addr", scrub_addr, 0);
                repeat (40) @(negedge clk);
            end
            forever begin : compare
                @(negedge clk);
                if (!resetn) begin
                    chk("rst_req", scrub_req, 0);
                    chk("rst_addr", scrub_addr, 0);
                    chk("rst_err_pulse", err_pulse, 0);
                    chk("rst_err_addr", err_addr, 0);
                    chk("rst_err_cnt", err_cnt, 0);
                    chk("rst_pass_done", pass_done, 0);
                    chk("rst_sat_cnt", s_cnt, 0);
                    m_addr = 0; m_cnt = 0; m_cnts = 0;
                    m_out = 0; e_pulse = 0; e_done = 0; m_eaddr = '0;
                end else begin
                    if (pass_done) n_done++;
                    chk("err_pulse", err_pulse, e_pulse);
                    chk("pass_done", pass_done, e_done);
                    chk("err_cnt", err_cnt, m_cnt);
                    chk("err_addr", err_addr, m_eaddr);
                    chk("sat_err_cnt", s_cnt, m_cnts);
                    chk("sat_err_pulse", s_pulse, e_pulse);
                    chk("sat_pass_done", s_done, e_done);
                    chk("sat_err_addr", s_eaddr, m_eaddr);
                    chk("sat_req", s_req, scrub_req);
                    if (scrub_req) begin
                        chk("scrub_addr", scrub_addr, m_addr);
                        chk("sat_addr", s_addr, m_addr);
                    end
                    e_pulse = 0;
                    e_done = 0;
                    mis = 0;
                    if (m_out && scrub_rvld) begin
                        mis = (par_of(scrub_rdata) != scrub_rpar);
                        if (mis) begin
                            e_pulse = 1;
                            m_eaddr = AW'(m_addr);
                        end
                        if (m_addr == WCNT - 1) e_done = 1;
                        m_addr = (m_addr + 1) % WCNT;
                        m_out = 0;
                    end
                    if (err_clr) begin
                        m_cnt = int'(mis);
                        m_cnts = int'(mis);
                    end else if (mis) begin
                        if (m_cnt < 65535) m_cnt++;
                        if (m_cnts < 15) m_cnts++;
                    end
                    if (scrub_req && scrub_gnt) m_out = 1;
                end
            end
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
